// File: rtl/elevator_motion_ctrl.sv
// Movement and door sequencer for a 3-floor elevator: latches calls into request LEDs,
// picks stops with a SCAN policy, and times floor-to-floor travel and door dwell.
module elevator_motion_ctrl #(
  parameter int TRAVEL_TICKS = 16,
  parameter int DOOR_TICKS   = 32,
  parameter int CNT_W        = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       st_btn,
  input  logic       nd_btn,
  input  logic       rd_btn,
  output logic [1:0] floor,
  output logic       st_led,
  output logic       nd_led,
  output logic       rd_led,
  output logic       is_mooving,
  output logic       dir_up,
  output logic       door_open
);

  typedef enum logic [1:0] {IDLE, MOVE_UP, MOVE_DN, DOOR} state_t;

  localparam logic [CNT_W-1:0] TRAVEL_LAST = CNT_W'(TRAVEL_TICKS - 1);
  localparam logic [CNT_W-1:0] DOOR_LAST   = CNT_W'(DOOR_TICKS - 1);

  state_t           state;
  logic [2:0]       leds;
  logic [CNT_W-1:0] counter;

  logic [2:0] btn, here, above, below, arrive_up, arrive_dn, latch_set, leds_set;
  logic       parked, call_here, any_above, any_below, travel_done, door_done;

  // One-hot floor masks; floor 2'b11 gives all-zero masks, which forces IDLE.
  assign btn       = {rd_btn, nd_btn, st_btn};
  assign here      = 3'b001 << floor;
  assign above     = {here[1] | here[0], here[0], 1'b0};
  assign below     = {1'b0, here[2], here[2] | here[1]};
  assign arrive_up = {here[1:0], 1'b0};
  assign arrive_dn = {1'b0, here[2:1]};

  // A call for the floor we are parked at opens the door instead of lighting a LED.
  assign parked      = (state == IDLE) || (state == DOOR);
  assign latch_set   = btn & ~(parked ? here : 3'b000);
  assign leds_set    = leds | latch_set;
  assign call_here   = |((btn | leds) & here);
  assign any_above   = |(leds & above);
  assign any_below   = |(leds & below);
  assign travel_done = (counter == TRAVEL_LAST);
  assign door_done   = (counter == DOOR_LAST);

  assign st_led = leds[0];
  assign nd_led = leds[1];
  assign rd_led = leds[2];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      floor      <= 2'd0;
      leds       <= 3'b000;
      dir_up     <= 1'b1;
      is_mooving <= 1'b0;
      door_open  <= 1'b0;
      counter    <= '0;
    end else begin
      leds <= leds_set;
      case (state)
        IDLE: begin
          counter <= '0;
          if (call_here) begin
            state     <= DOOR;
            door_open <= 1'b1;
            leds      <= leds_set & ~here;
          end else if (dir_up && any_above) begin
            state      <= MOVE_UP;
            is_mooving <= 1'b1;
          end else if (!dir_up && any_below) begin
            state      <= MOVE_DN;
            is_mooving <= 1'b1;
          end else if (dir_up && any_below) begin
            dir_up     <= 1'b0;
            state      <= MOVE_DN;
            is_mooving <= 1'b1;
          end else if (!dir_up && any_above) begin
            dir_up     <= 1'b1;
            state      <= MOVE_UP;
            is_mooving <= 1'b1;
          end
        end

        MOVE_UP: begin
          if (travel_done) begin
            counter <= '0;
            if (arrive_up == 3'b000) begin
              state      <= IDLE;
              is_mooving <= 1'b0;
            end else begin
              floor <= floor + 2'd1;
              if (|(leds & arrive_up)) begin
                state      <= DOOR;
                is_mooving <= 1'b0;
                door_open  <= 1'b1;
                leds       <= leds_set & ~arrive_up;
              end else if (!(|(leds & above & ~arrive_up))) begin
                state      <= IDLE;
                is_mooving <= 1'b0;
              end
            end
          end else begin
            counter <= counter + CNT_W'(1);
          end
        end

        MOVE_DN: begin
          if (travel_done) begin
            counter <= '0;
            if (arrive_dn == 3'b000) begin
              state      <= IDLE;
              is_mooving <= 1'b0;
            end else begin
              floor <= floor - 2'd1;
              if (|(leds & arrive_dn)) begin
                state      <= DOOR;
                is_mooving <= 1'b0;
                door_open  <= 1'b1;
                leds       <= leds_set & ~arrive_dn;
              end else if (!(|(leds & below & ~arrive_dn))) begin
                state      <= IDLE;
                is_mooving <= 1'b0;
              end
            end
          end else begin
            counter <= counter - CNT_W'(0) + CNT_W'(1);
          end
        end

        DOOR: begin
          // A fresh call for this floor restarts the dwell, even on its last cycle.
          if (|(btn & here)) begin
            counter <= '0;
          end else if (door_done) begin
            state     <= IDLE;
            door_open <= 1'b0;
            counter   <= '0;
          end else begin
            counter <= counter + CNT_W'(1);
          end
        end

        default: begin
          state      <= IDLE;
          is_mooving <= 1'b0;
          door_open  <= 1'b0;
          counter    <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_elevator_motion_ctrl.sv
// Self-checking bench for elevator_motion_ctrl: cycle-by-cycle vector table for the SCAN
// and door sequences, hand-written async-reset check, then a random soak with invariants.
module tb_elevator_motion_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       st_btn = 1'b0, nd_btn = 1'b0, rd_btn = 1'b0;
  logic [1:0] floor;
  logic       st_led, nd_led, rd_led, is_mooving, dir_up, door_open;

  int checks = 0;
  int passed = 0;

  typedef struct packed {
    logic [2:0] btn;   // {rd, nd, st}
    logic [1:0] fl;
    logic [2:0] leds;  // {rd, nd, st}
    logic       mv;
    logic       dir;
    logic       door;
  } vec_t;

  vec_t vecs[$];

  elevator_motion_ctrl #(
    .TRAVEL_TICKS(4),
    .DOOR_TICKS  (3),
    .CNT_W       (6)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .st_btn    (st_btn),
    .nd_btn    (nd_btn),
    .rd_btn    (rd_btn),
    .floor     (floor),
    .st_led    (st_led),
    .nd_led    (nd_led),
    .rd_led    (rd_led),
    .is_mooving(is_mooving),
    .dir_up    (dir_up),
    .door_open (door_open)
  );

  always #5 clk = ~clk;

  function automatic vec_t v(input logic [2:0] b, input logic [1:0] f, input logic [2:0] l,
                             input logic m, input logic d, input logic o);
    vec_t r;
    r.btn = b; r.fl = f; r.leds = l; r.mv = m; r.dir = d; r.door = o;
    return r;
  endfunction

  task automatic add(input vec_t x, input int n);
    repeat (n) vecs.push_back(x);
  endtask

  function automatic logic [7:0] observed();
    return {floor, rd_led, nd_led, st_led, is_mooving, dir_up, door_open};
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act === exp) begin
      passed++;
      $display("%s ok: {floor,leds,mv,dir,door}=%b", name, act);
    end else begin
      $display("FAIL %s: got {floor,leds,mv,dir,door}=%b required %b", name, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] b);
    {rd_btn, nd_btn, st_btn} = b;
  endtask

  initial begin
    int waited;
    // Scenario 1: call floor 2 from floor 0.
    add(v(3'b100, 2'd0, 3'b100, 1'b0, 1'b1, 1'b0), 1);
    add(v(3'b000, 2'd0, 3'b100, 1'b1, 1'b1, 1'b0), 4);
    add(v(3'b000, 2'd1, 3'b100, 1'b1, 1'b1, 1'b0), 4);
    add(v(3'b000, 2'd2, 3'b000, 1'b0, 1'b1, 1'b1), 3);
    add(v(3'b000, 2'd2, 3'b000, 1'b0, 1'b1, 1'b0), 1);
    // Scenario 3: at 2 with dir_up=1, call floor 0 -> reverse, pass floor 1.
    add(v(3'b001, 2'd2, 3'b001, 1'b0, 1'b1, 1'b0), 1);
    add(v(3'b000, 2'd2, 3'b001, 1'b1, 1'b0, 1'b0), 4);
    add(v(3'b000, 2'd1, 3'b001, 1'b1, 1'b0, 1'b0), 4);
    add(v(3'b000, 2'd0, 3'b000, 1'b0, 1'b0, 1'b1), 3);
    add(v(3'b000, 2'd0, 3'b000, 1'b0, 1'b0, 1'b0), 1);
    // Scenario 2: calls for 1 and 2 together, stop at 1 then continue.
    add(v(3'b110, 2'd0, 3'b110, 1'b0, 1'b0, 1'b0), 1);
    add(v(3'b000, 2'd0, 3'b110, 1'b1, 1'b1, 1'b0), 4);
    add(v(3'b000, 2'd1, 3'b100, 1'b0, 1'b1, 1'b1), 3);
    add(v(3'b000, 2'd1, 3'b100, 1'b0, 1'b1, 1'b0), 1);
    add(v(3'b000, 2'd1, 3'b100, 1'b1, 1'b1, 1'b0), 4);
    add(v(3'b000, 2'd2, 3'b000, 1'b0, 1'b1, 1'b1), 3);
    add(v(3'b000, 2'd2, 3'b000, 1'b0, 1'b1, 1'b0), 1);
    // Call for the current floor while IDLE: door opens, no LED.
    add(v(3'b100, 2'd2, 3'b000, 1'b0, 1'b1, 1'b1), 1);
    add(v(3'b000, 2'd2, 3'b000, 1'b0, 1'b1, 1'b1), 2);
    add(v(3'b000, 2'd2, 3'b000, 1'b0, 1'b1, 1'b0), 1);
    // Scenario 4: dwell restart at floor 1 on dwell cycle 2.
    add(v(3'b010, 2'd2, 3'b010, 1'b0, 1'b1, 1'b0), 1);
    add(v(3'b000, 2'd2, 3'b010, 1'b1, 1'b0, 1'b0), 4);
    add(v(3'b000, 2'd1, 3'b000, 1'b0, 1'b0, 1'b1), 2);
    add(v(3'b010, 2'd1, 3'b000, 1'b0, 1'b0, 1'b1), 1);
    add(v(3'b000, 2'd1, 3'b000, 1'b0, 1'b0, 1'b1), 2);
    add(v(3'b000, 2'd1, 3'b000, 1'b0, 1'b0, 1'b0), 1);
    // Button for the arrival floor on the arrival edge: clear wins; other floors latch in DOOR.
    add(v(3'b001, 2'd1, 3'b001, 1'b0, 1'b0, 1'b0), 1);
    add(v(3'b000, 2'd1, 3'b001, 1'b1, 1'b0, 1'b0), 4);
    add(v(3'b001, 2'd0, 3'b000, 1'b0, 1'b0, 1'b1), 1);
    add(v(3'b100, 2'd0, 3'b100, 1'b0, 1'b0, 1'b1), 1);
    add(v(3'b000, 2'd0, 3'b100, 1'b0, 1'b0, 1'b1), 1);
    add(v(3'b000, 2'd0, 3'b100, 1'b0, 1'b0, 1'b0), 1);

    repeat (2) @(posedge clk);
    #1;
    check("reset_state", observed(), 8'b00_000_010);
    reset = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].btn);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), observed(),
            {vecs[i].fl, vecs[i].leds, vecs[i].mv, vecs[i].dir, vecs[i].door});
    end

    // Scenario 5: asynchronous reset in the middle of MOVE_UP with two LEDs lit.
    drive(3'b000);
    @(posedge clk);
    #1;
    check("move_up_start", observed(), 8'b00_100_110);
    drive(3'b001);
    @(posedge clk);
    #1;
    drive(3'b000);
    check("st_latched_moving", observed(), 8'b00_101_110);
    #2 reset = 1'b1;
    #1;
    check("async_reset", observed(), 8'b00_000_010);
    @(posedge clk);
    #1;
    check("reset_held", observed(), 8'b00_000_010);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("requests_discarded", observed(), 8'b00_000_010);

    // Scenario 6: random pulses with per-cycle invariants.
    for (int c = 0; c < 10000; c++) begin
      st_btn = ($urandom_range(15) == 0);
      nd_btn = ($urandom_range(15) == 0);
      rd_btn = ($urandom_range(15) == 0);
      @(posedge clk);
      #1;
      checks++;
      if (floor != 2'b11 && !(is_mooving && door_open)) passed++;
      else $display("FAIL invariant cycle %0d: floor=%b mv=%b door=%b required floor!=11 and not both",
                    c, floor, is_mooving, door_open);
    end
    drive(3'b000);
    waited = 0;
    while ((st_led || nd_led || rd_led || is_mooving || door_open) && waited < 300) begin
      @(posedge clk);
      #1;
      waited++;
    end
    checks++;
    if (!(st_led || nd_led || rd_led || is_mooving || door_open)) begin
      passed++;
      $display("drain ok after %0d cycles", waited);
    end else begin
      $display("FAIL drain: leds=%b mv=%b door=%b after %0d cycles, required all 0",
               {rd_led, nd_led, st_led}, is_mooving, door_open, waited);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
